value_change_fifo: RTL and testbench

//  Upstream capture stage for 4-state value monitors. Samples a multi-bit net

---
 rtl/vcf_pkg.sv | 13 +
 rtl/vcf_store.sv | 63 ++++++
 rtl/value_change_fifo.sv | 62 ++++++
 tb/tb_value_change_fifo.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/vcf_pkg.sv
// vcf_pkg: shared defaults and 4-state change test for value_change_fifo
//   VCF_WIDTH_DEF  default sampled-net width
//   VCF_DEPTH_DEF  default FIFO depth
//   VCF_CMP_W      operand width of vcf_changed (callers zero-extend into it)
//   vcf_changed    1 when a and b differ, X and Z compared literally
package vcf_pkg;
   localparam int VCF_WIDTH_DEF = 4;
   localparam int VCF_DEPTH_DEF = 4;
   localparam int VCF_CMP_W     = 32;
   function automatic logic vcf_changed(input logic [VCF_CMP_W-1:0] a, input logic [VCF_CMP_W-1:0] b);
      return a !== b;
   endfunction
endpackage

// File: rtl/vcf_store.sv
// vcf_store: DEPTH x WIDTH FIFO with a registered head entry
//   clk, rst_n  clock, async active-low reset
//   push_i      write request; ignored when full unless a pop happens too
//   wdata_i     write data
//   ready_i     consumer accepts the head entry
//   valid_o     head entry available
//   data_o      registered head; holds its last value while empty
//   count_o     entries held, 0..DEPTH
//   full_o      count_o == DEPTH
module vcf_store
   import vcf_pkg::*;
#(
   parameter int WIDTH = VCF_WIDTH_DEF,
   parameter int DEPTH = VCF_DEPTH_DEF,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             ready_i,
   output logic             valid_o,
   output logic [WIDTH-1:0] data_o,
   output logic [AW:0]      count_o,
   output logic             full_o
);
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
   logic [AW:0]      count_q, count_d, rem;
   logic [WIDTH-1:0] head_q, head_d;
   logic             pop, wr;
   assign valid_o = count_q != '0;
   assign full_o  = count_q == (AW+1)'(DEPTH);
   assign data_o  = head_q;
   assign count_o = count_q;
   always_comb begin
      pop     = valid_o && ready_i;
      wr      = push_i && (!full_o || pop);
      wptr_d  = wr ? wptr_q + AW'(1) : wptr_q;
      rptr_d  = pop ? rptr_q + AW'(1) : rptr_q;
      count_d = count_q + (AW+1)'(wr) - (AW+1)'(pop);
      // Entries surviving the pop decide where the next head comes from:
      // older stored data if any remain, otherwise the entry being written now.
      rem     = count_q - (AW+1)'(pop);
      head_d  = rem != '0 ? (pop ? mem_q[rptr_d] : head_q) : (wr ? wdata_i : head_q);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         head_q  <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
         head_q  <= head_d;
      end
   end
   always_ff @(posedge clk) begin
      if (wr) mem_q[wptr_q] <= wdata_i;
   end
endmodule

// File: rtl/value_change_fifo.sv
// value_change_fifo: queues every 4-state change of a sampled net for a stallable consumer
//   clk, rst_n  clock, async active-low reset
//   en_i        sample enable
//   value_i     net under observation
//   clr_ovf_i   synchronous clear of overflow_o
//   out_valid   head entry available
//   out_ready   consumer accepts head entry
//   out_data    head entry, held while out_valid=0
//   out_count   entries held, 0..DEPTH
//   overflow_o  sticky: a change was dropped on a full FIFO
module value_change_fifo
   import vcf_pkg::*;
#(
   parameter int WIDTH = VCF_WIDTH_DEF,
   parameter int DEPTH = VCF_DEPTH_DEF,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en_i,
   input  logic [WIDTH-1:0] value_i,
   input  logic             clr_ovf_i,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [AW:0]      out_count,
   output logic             overflow_o
);
   logic [WIDTH-1:0] last_q, last_d;
   logic             primed_q, primed_d, ovf_q, ovf_d, push, drop, full;
   always_comb begin
      // The first enabled sample after reset always counts as a change.
      push     = en_i && (!primed_q || vcf_changed(VCF_CMP_W'(value_i), VCF_CMP_W'(last_q)));
      drop     = push && full && !(out_valid && out_ready);
      last_d   = en_i ? value_i : last_q;
      primed_d = en_i || primed_q;
      ovf_d    = drop || (ovf_q && !clr_ovf_i);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q   <= '0;
         primed_q <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         last_q   <= last_d;
         primed_q <= primed_d;
         ovf_q    <= ovf_d;
      end
   end
   assign overflow_o = ovf_q;
   vcf_store #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_store (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push),
      .wdata_i (value_i),
      .ready_i (out_ready),
      .valid_o (out_valid),
      .data_o  (out_data),
      .count_o (out_count),
      .full_o  (full)
   );
endmodule

// File: tb/tb_value_change_fifo.sv
// tb_value_change_fifo: scoreboard bench for value_change_fifo
module tb_value_change_fifo;
   import vcf_pkg::*;
   localparam int W  = VCF_WIDTH_DEF;
   localparam int D  = VCF_DEPTH_DEF;
   localparam int AW = $clog2(D);

   logic          clk, rst_n, en_i, clr_ovf_i, out_valid, out_ready, overflow_o;
   logic [W-1:0]  value_i, out_data;
   logic [AW:0]   out_count;

   int            checks = 0, errors = 0;
   logic [W-1:0]  sbq[$];
   int            mc = 0, nc = 0;
   bit            ovf_m = 0, novf = 0, primed_m = 0;
   logic [W-1:0]  last_m = '0;

   value_change_fifo #(.WIDTH(W), .DEPTH(D)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en_i       (en_i),
      .value_i    (value_i),
      .clr_ovf_i  (clr_ovf_i),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_count  (out_count),
      .overflow_o (overflow_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // One clock of stimulus: commit the prediction for the edge just taken,
   // then drive new inputs and predict their effect on the next edge.
   task automatic step(input bit en, input logic [W-1:0] v, input bit rdy, input bit clr);
      bit pop, push, drop;
      @(posedge clk);
      #1;
      mc = nc;
      ovf_m = novf;
      en_i = en; value_i = v; out_ready = rdy; clr_ovf_i = clr;
      pop  = rdy && mc > 0;
      push = en && (!primed_m || vcf_changed(VCF_CMP_W'(v), VCF_CMP_W'(last_m)));
      if (en) begin
         primed_m = 1;
         last_m = v;
      end
      drop = push && mc == D && !pop;
      if (push && !drop) sbq.push_back(v);
      nc = mc + int'(push && !drop) - int'(pop);
      novf = drop ? 1'b1 : clr ? 1'b0 : ovf_m;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      en_i = 0; value_i = '0; out_ready = 0; clr_ovf_i = 0;
      #1;
      chk("rst_valid", int'(out_valid), 0);
      chk("rst_count", int'(out_count), 0);
      chk("rst_ovf", int'(overflow_o), 0);
      chk("rst_data", int'(out_data), 0);
      sbq.delete();
      mc = 0; nc = 0; ovf_m = 0; novf = 0; primed_m = 0; last_m = '0;
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
   endtask

   // Monitor: compares state every cycle and pops the scoreboard on each handshake.
   always @(negedge clk) begin
      logic [W-1:0] exp_d;
      if (rst_n) begin
         checks += 3;
         if (int'(out_count) != mc) begin
            errors++;
            $display("FAIL count: got %0d expected %0d", out_count, mc);
         end
         if (out_valid !== (mc != 0)) begin
            errors++;
            $display("FAIL valid: got %b expected %b", out_valid, mc != 0);
         end
         if (overflow_o !== ovf_m) begin
            errors++;
            $display("FAIL overflow: got %b expected %b", overflow_o, ovf_m);
         end
         if (out_valid && out_ready) begin
            checks++;
            if (sbq.size() == 0) begin
               errors++;
               $display("FAIL data: got %b expected no entry", out_data);
            end else begin
               exp_d = sbq.pop_front();
               if (out_data !== exp_d) begin
                  errors++;
                  $display("FAIL data: got %b expected %b", out_data, exp_d);
               end
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [W-1:0] vx, v2[5];
      rst_n = 1'b1;
      en_i = 0; value_i = '0; out_ready = 0; clr_ovf_i = 0;
      #2;
      do_reset();
      // held value yields a single entry
      repeat (3) step(1, W'(5), 0, 0);
      step(0, '0, 0, 0);
      @(negedge clk);
      chk("t1_count", int'(out_count), 1);
      chk("t1_valid", int'(out_valid), 1);
      chk("t1_data", int'(out_data), 5);
      // repeats suppressed while streaming
      do_reset();
      v2 = '{W'(5), W'(5), W'(9), W'(9), W'(3)};
      foreach (v2[i]) step(1, v2[i], 1, 0);
      repeat (2) step(0, '0, 1, 0);
      // overflow, drain, re-presented value
      for (int i = 1; i <= 6; i++) step(1, W'(i), 0, 0);
      step(0, '0, 0, 0);
      @(negedge clk);
      chk("t3_count", int'(out_count), D);
      chk("t3_ovf", int'(overflow_o), 1);
      step(0, '0, 1, 1);
      repeat (4) step(0, '0, 1, 0);
      step(1, W'(6), 0, 0);
      step(0, '0, 0, 0);
      @(negedge clk);
      chk("t3_nopush", int'(out_count), 0);
      // full with simultaneous push and pop
      for (int i = 7; i <= 10; i++) step(1, W'(i), 0, 0);
      step(1, W'(11), 1, 0);
      step(0, '0, 0, 0);
      @(negedge clk);
      chk("t4_count", int'(out_count), D);
      chk("t4_ovf", int'(overflow_o), 0);
      repeat (5) step(0, '0, 1, 0);
      // changes into and out of X
      vx = 4'b01x1;
      step(1, W'(4'b0101), 1, 0);
      step(1, vx, 1, 0);
      step(1, vx, 1, 0);
      step(1, W'(4'b0101), 1, 0);
      repeat (2) step(0, '0, 1, 0);
      // async reset mid-drain
      for (int i = 1; i <= 3; i++) step(1, W'(i), 0, 0);
      step(0, '0, 1, 0);
      #2;
      do_reset();
      step(1, '0, 0, 0);
      step(0, '0, 0, 0);
      @(negedge clk);
      chk("t6_first", int'(out_count), 1);
      // randomized traffic
      repeat (2000) step($urandom_range(0, 9) < 8, W'($urandom_range(0, 3)),
                         $urandom_range(0, 1) == 1, $urandom_range(0, 9) == 0);
      for (int i = 0; i < 20 && sbq.size() != 0; i++) step(0, '0, 1, 0);
      step(0, '0, 0, 0);
      @(negedge clk);
      chk("drained", sbq.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
